// File: rtl/adam_aes_arb_pkg.sv
// Shared types and constants for the AES core arbiter.
// State encoding, requester limit and key/block widths.
package adam_aes_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  localparam int N_REQ_MAX = 8;
  localparam int KEY_W     = 256;
  localparam int BLK_W     = 128;

endpackage

// File: rtl/adam_aes_rr_picker.sv
// Rotate-priority encoder: first set bit of req at or after ptr.
// Ports: req, ptr in; onehot, idx, any out. Purely combinational.
module adam_aes_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found;
  int   j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/adam_aes_arbiter.sv
// Round-robin arbiter sharing one AES core among N_REQ requesters.
// Ports: clk, reset_n; req_valid/encdec/keylen/key/block per
// requester; gnt, rsp_valid, rsp_result, busy back to them;
// core_start/ready/result_valid/result and muxed core_* payload.
// Optional: ADAM_AES_ARB_KEY_AFFINITY_EN prefers requesters whose
// key equals the last granted key, bounded by AFFINITY_MAX.
module adam_aes_arbiter
  import adam_aes_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int AFFINITY_MAX = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_encdec,
  input  logic [N_REQ-1:0]            req_keylen,
  input  logic [N_REQ-1:0][KEY_W-1:0] req_key,
  input  logic [N_REQ-1:0][BLK_W-1:0] req_block,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [BLK_W-1:0]            rsp_result,
  output logic                        busy,
  output logic                        core_start,
  input  logic                        core_ready,
  input  logic                        core_result_valid,
  input  logic [BLK_W-1:0]            core_result,
  output logic                        core_encdec,
  output logic                        core_keylen,
  output logic [KEY_W-1:0]            core_key,
  output logic [BLK_W-1:0]            core_block
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > N_REQ_MAX ||
      AFFINITY_MAX < 1) begin : g_bad_cfg
    $error("adam_aes_arbiter: bad parameters");
  end

  arb_state_t     state;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  ptr_nxt;

  logic [N_REQ-1:0] rr_oh;
  logic [IW-1:0]    rr_idx;
  logic             rr_any;
  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;

  adam_aes_rr_picker #(.N(N_REQ), .IW(IW)) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (rr_oh),
    .idx    (rr_idx),
    .any    (rr_any)
  );

`ifdef ADAM_AES_ARB_KEY_AFFINITY_EN
  localparam int AW = $clog2(AFFINITY_MAX + 1);

  logic [KEY_W-1:0] last_key;
  logic             last_keylen;
  logic             last_vld;
  logic [AW-1:0]    aff_cnt;
  logic [AW-1:0]    aff_cnt_nxt;

  logic [N_REQ-1:0] key_match;
  logic [N_REQ-1:0] m_oh;
  logic [IW-1:0]    m_idx;
  logic             m_any;

  always_comb begin
    key_match = '0;
    for (int i = 0; i < N_REQ; i++) begin
      key_match[i] = req_valid[i] && last_vld &&
                     (req_keylen[i] == last_keylen) &&
                     (req_key[i] == last_key);
    end
  end

  adam_aes_rr_picker #(.N(N_REQ), .IW(IW)) u_match (
    .req    (key_match),
    .ptr    (ptr),
    .onehot (m_oh),
    .idx    (m_idx),
    .any    (m_any)
  );

  // A match that overrides the RR choice is counted; once the
  // budget is spent the RR winner gets through and the run resets.
  always_comb begin
    win_oh      = rr_oh;
    win_idx     = rr_idx;
    aff_cnt_nxt = '0;
    if (m_any && (m_idx != rr_idx)) begin
      if (aff_cnt < AW'(AFFINITY_MAX)) begin
        win_oh      = m_oh;
        win_idx     = m_idx;
        aff_cnt_nxt = aff_cnt + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_key    <= '0;
      last_keylen <= 1'b0;
      last_vld    <= 1'b0;
      aff_cnt     <= '0;
    end else if (state == ARB_IDLE && rr_any && core_ready) begin
      last_key    <= req_key[win_idx];
      last_keylen <= req_keylen[win_idx];
      last_vld    <= 1'b1;
      aff_cnt     <= aff_cnt_nxt;
    end
  end
`else
  assign win_oh  = rr_oh;
  assign win_idx = rr_idx;
`endif

  assign ptr_nxt = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      gnt        <= '0;
      owner      <= '0;
      ptr        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      core_start <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (rr_any && core_ready) begin
            gnt        <= win_oh;
            owner      <= win_idx;
            core_start <= 1'b1;
            state      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          core_start <= 1'b0;
          state      <= ARB_BUSY;
        end
        ARB_BUSY: begin
          if (core_result_valid) begin
            rsp_result <= core_result;
            rsp_valid  <= gnt;
            state      <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          rsp_valid <= '0;
          gnt       <= '0;
          ptr       <= ptr_nxt;
          state     <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy = (state != ARB_IDLE);

  logic own_act;
  assign own_act = |gnt;

  assign core_encdec = own_act ? req_encdec[owner] : 1'b0;
  assign core_keylen = own_act ? req_keylen[owner] : 1'b0;
  assign core_key    = own_act ? req_key[owner]    : '0;
  assign core_block  = own_act ? req_block[owner]  : '0;

endmodule
